// File: rtl/alu_issue_pkg.sv
// Shared decode constants, the issued-bundle type and the one-hot ALU opcode helper.
package alu_issue_pkg;

  localparam int unsigned XLEN_C = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN_C-1:0] op1;
    logic [XLEN_C-1:0] op2;
    logic [7:0]        opcode;
    logic              alt;
    logic [4:0]        rd_addr;
    logic              rd_we;
    logic              illegal;
  } bundle_t;

  function automatic logic [7:0] alu_onehot(input logic [2:0] f3);
    return 8'b0000_0001 << f3;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Execute-side bundle: issue stage drives it as master, the ALU consumes it as slave.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic [XLEN_C-1:0] op1;
  logic [XLEN_C-1:0] op2;
  logic [7:0]        alu_opcode;
  logic              alu_alt;
  logic [4:0]        rd_addr;
  logic              rd_we;
  logic              illegal;

  modport master (
    output op_valid, op1, op2, alu_opcode, alu_alt, rd_addr, rd_we, illegal,
    input  op_ready
  );

  modport slave (
    input  op_valid, op1, op2, alu_opcode, alu_alt, rd_addr, rd_we, illegal,
    output op_ready
  );
endinterface

// File: rtl/alu_issue_dec.sv
// Combinational RV32I ALU-class decode: builds the next issue bundle from the instruction word.
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [31:0]       instr_i,
  input  logic [31:0]       pc_i,
  input  logic [XLEN_C-1:0] rs1_data_i,
  input  logic [XLEN_C-1:0] rs2_data_i,
  output bundle_t           bundle_o
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;

  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];

  always_comb begin
    bundle_o = '0;
    legal    = 1'b0;
    case (instr_i[6:0])
      OPC_OP: begin
        legal           = (f7 == F7_BASE) ||
                          ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL)));
        bundle_o.op1    = rs1_data_i;
        bundle_o.op2    = rs2_data_i;
        bundle_o.opcode = alu_onehot(f3);
        bundle_o.alt    = instr_i[30];
      end
      OPC_OPIMM: begin
        bundle_o.op1    = rs1_data_i;
        bundle_o.opcode = alu_onehot(f3);
        case (f3)
          F3_SLL: begin
            legal        = (f7 == F7_BASE);
            bundle_o.op2 = {27'd0, instr_i[24:20]};
          end
          F3_SRL: begin
            legal        = (f7 == F7_BASE) || (f7 == F7_ALT);
            bundle_o.op2 = {27'd0, instr_i[24:20]};
            bundle_o.alt = instr_i[30];
          end
          default: begin
            legal        = 1'b1;
            bundle_o.op2 = {{20{instr_i[31]}}, instr_i[31:20]};
          end
        endcase
      end
      OPC_LUI: begin
        legal           = 1'b1;
        bundle_o.op2    = {instr_i[31:12], 12'd0};
        bundle_o.opcode = alu_onehot(F3_ADD);
      end
      OPC_AUIPC: begin
        legal           = 1'b1;
        bundle_o.op1    = pc_i;
        bundle_o.op2    = {instr_i[31:12], 12'd0};
        bundle_o.opcode = alu_onehot(F3_ADD);
      end
      default: legal = 1'b0;
    endcase

    // Illegal bundles are still issued, but scrubbed so nothing downstream acts on them.
    if (!legal) begin
      bundle_o         = '0;
      bundle_o.illegal = 1'b1;
    end else begin
      bundle_o.rd_addr = instr_i[11:7];
      bundle_o.rd_we   = (instr_i[11:7] != 5'd0);
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage: one-entry output register with pass-through ready and a legal-issue counter.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [31:0]       instr_i,
  input  logic [31:0]       pc_i,
  output logic [4:0]        rs1_addr_o,
  output logic [4:0]        rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  alu_issue_if.master       op_if,
  output logic [31:0]       issue_count_o
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic        state_q, state_d;
  bundle_t     bundle_q, bundle_d;
  bundle_t     dec_bundle;
  logic [31:0] count_q, count_d;
  logic        accept, consume;

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  alu_issue_dec u_dec (
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .bundle_o   (dec_bundle)
  );

  assign instr_ready_o = (state_q == ST_EMPTY) || op_if.op_ready;
  assign accept        = instr_valid_i && instr_ready_o;
  assign consume       = (state_q == ST_FULL) && op_if.op_ready;

  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    count_d  = count_q;
    // A consume in a flush cycle still counts; flush only cancels the state/load.
    if (consume && !bundle_q.illegal) begin
      count_d = count_q + 32'd1;
    end
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d  = ST_FULL;
      bundle_d = dec_bundle;
    end else if (consume) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_EMPTY;
      bundle_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      count_q  <= count_d;
    end
  end

  assign op_if.op_valid   = (state_q == ST_FULL);
  assign op_if.op1        = bundle_q.op1;
  assign op_if.op2        = bundle_q.op2;
  assign op_if.alu_opcode = bundle_q.opcode;
  assign op_if.alu_alt    = bundle_q.alt;
  assign op_if.rd_addr    = bundle_q.rd_addr;
  assign op_if.rd_we      = bundle_q.rd_we;
  assign op_if.illegal    = bundle_q.illegal;
  assign issue_count_o    = count_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed test-plan cases, random traffic, flush and async reset.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        iv = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        ready;
  logic [4:0]  a1, a2;
  logic [31:0] d1, d2, cnt;
  logic [31:0] rf [32];

  alu_issue_if op_if ();

  alu_issue #(.XLEN(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .instr_valid_i (iv),
    .instr_ready_o (ready),
    .instr_i       (instr),
    .pc_i          (pc),
    .rs1_addr_o    (a1),
    .rs2_addr_o    (a2),
    .rs1_data_i    (d1),
    .rs2_data_i    (d2),
    .op_if         (op_if),
    .issue_count_o (cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    d1 = rf[a1];
    d2 = rf[a2];
  end

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [7:0]  opc;
    logic        alt;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_count = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model written directly from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ok;
    logic [31:0] imm_i;
    f3    = w[14:12];
    f7    = w[31:25];
    imm_i = {{20{w[31]}}, w[31:20]};
    e     = '{default: '0};
    ok    = 1'b0;
    if (w[6:0] == 7'h33) begin
      ok    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.op1 = a; e.op2 = b; e.alt = w[30]; e.opc = 8'd1 << f3;
    end else if (w[6:0] == 7'h13) begin
      e.op1 = a; e.opc = 8'd1 << f3;
      if (f3 == 3'd1) begin
        ok = (f7 == 7'h00); e.op2 = 32'(w[24:20]);
      end else if (f3 == 3'd5) begin
        ok = (f7 == 7'h00) || (f7 == 7'h20); e.op2 = 32'(w[24:20]); e.alt = w[30];
      end else begin
        ok = 1'b1; e.op2 = imm_i;
      end
    end else if (w[6:0] == 7'h37 || w[6:0] == 7'h17) begin
      ok    = 1'b1;
      e.op1 = (w[6:0] == 7'h17) ? p : 32'd0;
      e.op2 = w & 32'hFFFFF000;
      e.opc = 8'h01;
    end
    if (!ok) begin
      e     = '{default: '0};
      e.ill = 1'b1;
    end else begin
      e.rd = w[11:7];
      e.we = (w[11:7] != 0);
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned k, r;
    w = $urandom;
    k = $urandom_range(0, 9);
    r = $urandom_range(0, 3);
    if (k <= 5) begin
      w[6:0] = (k <= 2) ? 7'h33 : 7'h13;
      if (r <= 1)      w[31:25] = 7'h00;
      else if (r == 2) w[31:25] = 7'h20;
    end else if (k == 6) w[6:0] = 7'h37;
    else if (k == 7)     w[6:0] = 7'h17;
    return w;
  endfunction

  // One clock of stimulus; an accepted, unflushed instruction's expected bundle is queued at the edge.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p,
                      input logic rdy, input logic fl);
    logic acc;
    exp_t e;
    iv = v; instr = w; pc = p; op_if.op_ready = rdy; flush = fl;
    @(negedge clk);
    acc = v && ready && !fl;
    e   = model(w, p, rf[w[19:15]], rf[w[24:20]]);
    @(posedge clk);
    if (acc) q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      chk("issue_count", cnt, exp_count);
      if (op_if.op_valid && (op_if.op_ready || flush)) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bundle: got op_valid=1 expected no pending bundle");
        end else begin
          e = q.pop_front();
          if (op_if.op_ready) begin
            chk("op1", op_if.op1, e.op1);
            chk("op2", op_if.op2, e.op2);
            chk("alu_opcode", 32'(op_if.alu_opcode), 32'(e.opc));
            chk("alu_alt", 32'(op_if.alu_alt), 32'(e.alt));
            chk("rd_addr", 32'(op_if.rd_addr), 32'(e.rd));
            chk("rd_we", 32'(op_if.rd_we), 32'(e.we));
            chk("illegal", 32'(op_if.illegal), 32'(e.ill));
            if (!e.ill) exp_count = exp_count + 1;
          end
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_op_valid"}, 32'(op_if.op_valid), 32'd0);
    chk({tag, "_illegal"}, 32'(op_if.illegal), 32'd0);
    chk({tag, "_rd_we"}, 32'(op_if.rd_we), 32'd0);
    chk({tag, "_op1"}, op_if.op1, 32'd0);
    chk({tag, "_op2"}, op_if.op2, 32'd0);
    chk({tag, "_opcode"}, 32'(op_if.alu_opcode), 32'd0);
    chk({tag, "_alt"}, 32'(op_if.alu_alt), 32'd0);
    chk({tag, "_rd_addr"}, 32'(op_if.rd_addr), 32'd0);
    chk({tag, "_count"}, cnt, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    op_if.op_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    #12;
    chk_reset("rst");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_instr_ready", 32'(ready), 32'd1);

    step(1'b1, 32'h002081B3, 32'h100, 1'b0, 1'b0);
    chk("add_valid", 32'(op_if.op_valid), 32'd1);
    chk("add_opcode", 32'(op_if.alu_opcode), 32'h01);
    chk("add_alt", 32'(op_if.alu_alt), 32'd0);
    chk("add_op1", op_if.op1, 32'd5);
    chk("add_op2", op_if.op2, 32'd7);
    chk("add_rd", 32'(op_if.rd_addr), 32'd3);
    chk("add_we", 32'(op_if.rd_we), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h402081B3, 32'h104, 1'b0, 1'b0);
      chk("bp_op1", op_if.op1, 32'd5);
      chk("bp_op2", op_if.op2, 32'd7);
      chk("bp_valid", 32'(op_if.op_valid), 32'd1);
      chk("bp_instr_ready", 32'(ready), 32'd0);
    end
    step(1'b1, 32'h402081B3, 32'h104, 1'b0, 1'b1);
    chk("flush_valid", 32'(op_if.op_valid), 32'd0);

    step(1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0);
    chk("sub_alt", 32'(op_if.alu_alt), 32'd1);
    step(1'b1, 32'hFFF00093, 32'h108, 1'b1, 1'b0);
    chk("addi_op2", op_if.op2, 32'hFFFFFFFF);
    chk("addi_alt", 32'(op_if.alu_alt), 32'd0);
    step(1'b1, 32'h40435293, 32'h10C, 1'b1, 1'b0);
    chk("srai_opcode", 32'(op_if.alu_opcode), 32'h20);
    chk("srai_alt", 32'(op_if.alu_alt), 32'd1);
    chk("srai_op2", op_if.op2, 32'd4);
    step(1'b1, 32'h123453B7, 32'h110, 1'b1, 1'b0);
    chk("lui_op1", op_if.op1, 32'd0);
    chk("lui_op2", op_if.op2, 32'h12345000);
    step(1'b1, 32'h0000007F, 32'h114, 1'b1, 1'b0);
    chk("ill_flag", 32'(op_if.illegal), 32'd1);
    chk("ill_we", 32'(op_if.rd_we), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("ill_count", cnt, 32'd4);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 31)] = $urandom;
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end

    step(1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    q.delete();
    exp_count = '0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      step($urandom_range(0, 1) != 0, rand_instr(), $urandom, $urandom_range(0, 1) != 0, 1'b0);
    end
    for (int n = 0; n < 4; n++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain_queue", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
